// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared processor package: architectural widths plus the memory arbiter's
// FSM state encoding and requester IDs.
//   ARCH_BITS        - address width
//   MEMORY_LINE_BITS - width of one memory line
//   arb_state_e      - IDLE / BUSY / RESP
//   req_id_e         - REQ_D / REQ_W / REQ_I; the numeric order is also the
//                      round-robin rotation order (d -> w -> i)
// ---------------------------------------------------------------------------
package proc_pkg;

    localparam int ARCH_BITS        = 32;
    localparam int MEMORY_LINE_BITS = 64;
    localparam int NUM_REQ          = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        REQ_D = 2'd0,
        REQ_W = 2'd1,
        REQ_I = 2'd2
    } req_id_e;

    // Requester that follows 'id' in the d -> w -> i rotation.
    function automatic req_id_e next_req(input req_id_e id);
        case (id)
            REQ_D:   return REQ_W;
            REQ_W:   return REQ_I;
            default: return REQ_D;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational 3-way grant selector. Starting at the requester named by
// 'ptr' and walking d -> w -> i (wrapping), the first active request wins.
//   req [NUM_REQ-1:0] : requests indexed by req_id_e (bit0 d, bit1 w, bit2 i)
//   ptr               : requester holding highest priority this cycle
//   gnt [NUM_REQ-1:0] : one-hot grant, all zero when no request is active
// ---------------------------------------------------------------------------
module mem_arb_pick
    import proc_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_e            ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = 2'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates icache fills, dcache fills and store-buffer drains onto a single
// memory port. One transaction at a time: IDLE grants, BUSY holds the request
// on the memory port until memAck, RESP pulses the requester's ack.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration
// (d -> w -> i); otherwise fixed priority dReq > wMemReq > iReq.
//   clk, rst                     : clock, synchronous active-high reset
//   iReq/iAddr  -> iAck/iData    : icache line fill
//   dReq/dAddr  -> dAck/dData    : dcache line fill
//   wMemReq/wAddrMem/wDataMem -> wMemAck : store-buffer write
//   memReq/memWe/memAddr/memWData, memAck/memRData : memory port
//   memErr                       : sticky watchdog expiry flag
// Parameter WDT_CYCLES (1..255): BUSY cycles without memAck before memErr.
// ---------------------------------------------------------------------------
module mem_arbiter
    import proc_pkg::*;
#(
    parameter int unsigned WDT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        iReq,
    input  logic [ARCH_BITS-1:0]        iAddr,
    output logic                        iAck,
    output logic [MEMORY_LINE_BITS-1:0] iData,
    input  logic                        dReq,
    input  logic [ARCH_BITS-1:0]        dAddr,
    output logic                        dAck,
    output logic [MEMORY_LINE_BITS-1:0] dData,
    input  logic                        wMemReq,
    input  logic [ARCH_BITS-1:0]        wAddrMem,
    input  logic [MEMORY_LINE_BITS-1:0] wDataMem,
    output logic                        wMemAck,
    output logic                        memReq,
    output logic                        memWe,
    output logic [ARCH_BITS-1:0]        memAddr,
    output logic [MEMORY_LINE_BITS-1:0] memWData,
    input  logic                        memAck,
    input  logic [MEMORY_LINE_BITS-1:0] memRData,
    output logic                        memErr
);

    arb_state_e                  state_q, state_d;
    req_id_e                     gnt_id_q, gnt_id_d;
    logic [ARCH_BITS-1:0]        addr_q, addr_d;
    logic [MEMORY_LINE_BITS-1:0] wdata_q, wdata_d;
    logic                        we_q, we_d;
    logic [7:0]                  wdt_q, wdt_d, wdt_inc;
    logic                        err_q, err_d;
    logic [MEMORY_LINE_BITS-1:0] idata_q, idata_d;
    logic [MEMORY_LINE_BITS-1:0] ddata_q, ddata_d;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] gnt;
    req_id_e            pick_id;
    req_id_e            pick_ptr;

    assign req_vec = {iReq, wMemReq, dReq};

`ifdef MEM_ARB_RR_EN
    req_id_e ptr_q, ptr_d;
    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = REQ_D;
`endif

    mem_arb_pick u_pick (
        .req (req_vec),
        .ptr (pick_ptr),
        .gnt (gnt)
    );

    always_comb begin
        pick_id = REQ_D;
        if (gnt[REQ_W])      pick_id = REQ_W;
        else if (gnt[REQ_I]) pick_id = REQ_I;
    end

    // Watchdog saturates so a hung memory never wraps it back under the limit.
    assign wdt_inc = (wdt_q == 8'hFF) ? 8'hFF : wdt_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        wdt_d    = wdt_q;
        err_d    = err_q;
        idata_d  = idata_q;
        ddata_d  = ddata_q;
`ifdef MEM_ARB_RR_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    state_d  = BUSY;
                    gnt_id_d = pick_id;
                    wdt_d    = 8'd0;
                    we_d     = (pick_id == REQ_W);
                    wdata_d  = (pick_id == REQ_W) ? wDataMem : '0;
                    case (pick_id)
                        REQ_W:   addr_d = wAddrMem;
                        REQ_I:   addr_d = iAddr;
                        default: addr_d = dAddr;
                    endcase
`ifdef MEM_ARB_RR_EN
                    ptr_d = next_req(pick_id);
`endif
                end
            end
            BUSY: begin
                wdt_d = wdt_inc;
                if (memAck) begin
                    state_d = RESP;
                    if (gnt_id_q == REQ_D) ddata_d = memRData;
                    if (gnt_id_q == REQ_I) idata_d = memRData;
                end else if (wdt_inc == 8'(WDT_CYCLES)) begin
                    err_d = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_id_q <= REQ_D;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            wdt_q    <= 8'd0;
            err_q    <= 1'b0;
            idata_q  <= '0;
            ddata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q    <= REQ_D;
`endif
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            wdt_q    <= wdt_d;
            err_q    <= err_d;
            idata_q  <= idata_d;
            ddata_q  <= ddata_d;
`ifdef MEM_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign memReq   = (state_q == BUSY);
    assign memWe    = we_q;
    assign memAddr  = addr_q;
    assign memWData = wdata_q;
    assign iAck     = (state_q == RESP) && (gnt_id_q == REQ_I);
    assign dAck     = (state_q == RESP) && (gnt_id_q == REQ_D);
    assign wMemAck  = (state_q == RESP) && (gnt_id_q == REQ_W);
    assign iData    = idata_q;
    assign dData    = ddata_q;
    assign memErr   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter (WDT_CYCLES = 20). Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import proc_pkg::*;

    localparam int AW = ARCH_BITS;
    localparam int LW = MEMORY_LINE_BITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          iReq, dReq, wMemReq, memAck;
    logic [AW-1:0] iAddr, dAddr, wAddrMem;
    logic [LW-1:0] wDataMem, memRData;
    logic          iAck, dAck, wMemAck, memReq, memWe, memErr;
    logic [LW-1:0] iData, dData, memWData;
    logic [AW-1:0] memAddr;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WDT_CYCLES(20)) dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iData(iData),
        .dReq(dReq), .dAddr(dAddr), .dAck(dAck), .dData(dData),
        .wMemReq(wMemReq), .wAddrMem(wAddrMem), .wDataMem(wDataMem), .wMemAck(wMemAck),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memAck(memAck), .memRData(memRData), .memErr(memErr)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge out of IDLE: the granted request must appear on the memory port.
    task automatic grant_check(input string tag, input logic [AW-1:0] addr,
                               input logic we, input logic [LW-1:0] wd);
        tick();
        check_val({tag, "_memReq"}, 64'(memReq), 64'd1);
        check_val({tag, "_memAddr"}, 64'(memAddr), 64'(addr));
        check_val({tag, "_memWe"}, 64'(memWe), 64'(we));
        check_val({tag, "_memWData"}, 64'(memWData), 64'(wd));
    endtask

    // Memory acks on the dly-th edge after memReq rose; then RESP and IDLE.
    task automatic finish_txn(input string tag, input int dly, input logic [LW-1:0] rd,
                              input logic [2:0] exp_ack, input logic [AW-1:0] addr,
                              input logic we, input logic [LW-1:0] wd);
        for (int i = 1; i < dly; i++) tick();
        check_val({tag, "_hold_req"}, 64'(memReq), 64'd1);
        check_val({tag, "_hold_addr"}, 64'(memAddr), 64'(addr));
        memAck   = 1'b1;
        memRData = rd;
        tick();
        memAck   = 1'b0;
        memRData = '0;
        check_val({tag, "_ack"}, 64'({iAck, dAck, wMemAck}), 64'(exp_ack));
        check_val({tag, "_req_drop"}, 64'(memReq), 64'd0);
        check_val({tag, "_resp_we"}, 64'(memWe), 64'(we));
        check_val({tag, "_resp_addr"}, 64'(memAddr), 64'(addr));
        if (we) check_val({tag, "_resp_wdata"}, 64'(memWData), 64'(wd));
        if (exp_ack == 3'b010) check_val({tag, "_dData"}, 64'(dData), 64'(rd));
        if (exp_ack == 3'b100) check_val({tag, "_iData"}, 64'(iData), 64'(rd));
        tick();
        check_val({tag, "_ack_end"}, 64'({iAck, dAck, wMemAck}), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    localparam logic [AW-1:0] D_A = 32'h200, W_A = 32'h400, I_A = 32'h300;
    localparam logic [LW-1:0] W_D = 64'h1111_2222_3333_4444;

    initial begin
        logic [1:0] seq [4];
        rst = 1'b1; iReq = 0; dReq = 0; wMemReq = 0; memAck = 0;
        iAddr = '0; dAddr = '0; wAddrMem = '0; wDataMem = '0; memRData = '0;
        do_reset();
        check_val("rst_outs", 64'({iAck, dAck, wMemAck, memReq, memWe, memErr}), 64'd0);
        check_val("rst_addr", 64'(memAddr), 64'd0);
        check_val("rst_data", 64'(iData | dData | memWData), 64'd0);

        // Single dcache fill, memory responds 10 cycles after memReq.
        dReq = 1'b1; dAddr = 32'h100;
        grant_check("t1", 32'h100, 1'b0, '0);
        dReq = 1'b0;
        finish_txn("t1", 10, 64'hCAFE, 3'b010, 32'h100, 1'b0, '0);
        check_val("t1_dData_hold", 64'(dData), 64'hCAFE);

        // All three requests at once: d, then w, then i.
        do_reset();
        dReq = 1; iReq = 1; wMemReq = 1;
        dAddr = D_A; iAddr = I_A; wAddrMem = W_A; wDataMem = W_D;
        grant_check("t2_d", D_A, 1'b0, '0);
        dReq = 0;
        finish_txn("t2_d", 3, 64'hD1, 3'b010, D_A, 1'b0, '0);
        grant_check("t2_w", W_A, 1'b1, W_D);
        wMemReq = 0;
        finish_txn("t2_w", 2, 64'hBAD, 3'b001, W_A, 1'b1, W_D);
        grant_check("t2_i", I_A, 1'b0, '0);
        iReq = 0;
        finish_txn("t2_i", 4, 64'h1CE, 3'b100, I_A, 1'b0, '0);
        check_val("t2_dData_hold", 64'(dData), 64'hD1);

        // All three held high for four transactions.
`ifdef MEM_ARB_RR_EN
        seq = '{REQ_D, REQ_W, REQ_I, REQ_D};
`else
        seq = '{REQ_D, REQ_D, REQ_D, REQ_D};
`endif
        do_reset();
        dReq = 1; iReq = 1; wMemReq = 1;
        for (int n = 0; n < 4; n++) begin
            case (seq[n])
                REQ_W: begin
                    grant_check("t3_w", W_A, 1'b1, W_D);
                    finish_txn("t3_w", 2, 64'h33, 3'b001, W_A, 1'b1, W_D);
                end
                REQ_I: begin
                    grant_check("t3_i", I_A, 1'b0, '0);
                    finish_txn("t3_i", 2, 64'h44 + 64'(n), 3'b100, I_A, 1'b0, '0);
                end
                default: begin
                    grant_check("t3_d", D_A, 1'b0, '0);
                    finish_txn("t3_d", 2, 64'h55 + 64'(n), 3'b010, D_A, 1'b0, '0);
                end
            endcase
        end
        dReq = 0; iReq = 0; wMemReq = 0;

        // Store address/data change while BUSY; the held request becomes
        // a second transaction with the new values.
        wMemReq = 1; wAddrMem = 32'h500; wDataMem = 64'hAA;
        grant_check("t4_a", 32'h500, 1'b1, 64'hAA);
        wAddrMem = 32'h600; wDataMem = 64'hBB;
        finish_txn("t4_a", 3, 64'h0, 3'b001, 32'h500, 1'b1, 64'hAA);
        grant_check("t4_b", 32'h600, 1'b1, 64'hBB);
        wMemReq = 0;
        finish_txn("t4_b", 2, 64'h0, 3'b001, 32'h600, 1'b1, 64'hBB);

        // Watchdog: no memAck for 20 BUSY cycles, then a late ack.
        dReq = 1; dAddr = 32'h700;
        grant_check("t5", 32'h700, 1'b0, '0);
        dReq = 0;
        for (int i = 0; i < 19; i++) tick();
        check_val("t5_err_before", 64'(memErr), 64'd0);
        tick();
        check_val("t5_err_set", 64'(memErr), 64'd1);
        check_val("t5_still_busy", 64'(memReq), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        check_val("t5_err_sticky", 64'(memErr), 64'd1);
        finish_txn("t5", 1, 64'h1A7E, 3'b010, 32'h700, 1'b0, '0);
        check_val("t5_err_after", 64'(memErr), 64'd1);

        // Reset during BUSY cycle 3, then a stray memAck.
        do_reset();
        check_val("t6_err_clr", 64'(memErr), 64'd0);
        dReq = 1; dAddr = 32'h800;
        grant_check("t6", 32'h800, 1'b0, '0);
        dReq = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t6_ctl", 64'({iAck, dAck, wMemAck, memReq, memWe, memErr}), 64'd0);
        check_val("t6_addr", 64'(memAddr), 64'd0);
        check_val("t6_data", 64'(iData | dData | memWData), 64'd0);
        tick();
        tick();
        memAck = 1'b1; memRData = 64'hDEAD;
        tick();
        memAck = 1'b0; memRData = '0;
        check_val("t6_stray_ack", 64'({iAck, dAck, wMemAck, memReq}), 64'd0);
        check_val("t6_stray_data", 64'(dData), 64'd0);
        tick();
        check_val("t6_stray_ack2", 64'({iAck, dAck, wMemAck}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WDT_CYCLES, default 255: memory-response watchdog limit in cycles, range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have iReq / iAddr, inputs, 1 / ARCH_BITS bits: icache line-fill read request and its address.
REQ-005 SHALL have iAck / iData, outputs, 1 / MEMORY_LINE_BITS bits: icache completion pulse and the fill line.
REQ-006 SHALL have dReq / dAddr, inputs, 1 / ARCH_BITS bits: dcache line-fill read request and its address.
REQ-007 SHALL have dAck / dData, outputs, 1 / MEMORY_LINE_BITS bits: dcache completion pulse and the fill line.
REQ-008 SHALL have wMemReq / wAddrMem / wDataMem, inputs, 1 / ARCH_BITS / MEMORY_LINE_BITS bits: store-buffer drain write.
REQ-009 SHALL have wMemAck, output, 1 bit: store-buffer write completion pulse.
REQ-010 SHALL have memReq / memWe / memAddr / memWData, outputs, 1 / 1 / ARCH_BITS / MEMORY_LINE_BITS bits: memory port.
REQ-011 SHALL have memAck / memRData, inputs, 1 / MEMORY_LINE_BITS bits: memory completion pulse and read data.
REQ-012 SHALL have memErr, output, 1 bit: sticky watchdog-expiry flag.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-014 In IDLE with any request high, SHALL grant one requester, register its address, data and write flag, and enter BUSY.
REQ-015 SHALL use fixed grant priority dReq > wMemReq > iReq unless MEM_ARB_RR_EN is defined.
REQ-016 In BUSY, memReq SHALL be 1 and memAddr/memWData/memWe SHALL hold the registered values stable until memAck.
REQ-017 memWe SHALL be 1 only for a wMemReq grant; memWData SHALL be 0 for read grants.
REQ-018 On memAck in BUSY, SHALL capture memRData, drop memReq the next cycle, and enter RESP.
REQ-019 In RESP, SHALL pulse exactly one ack (iAck, dAck or wMemAck) for the granted requester for one cycle, then enter IDLE.
REQ-020 iData/dData SHALL carry the captured line during their ack cycle and SHALL hold their last value otherwise.
REQ-021 Requests SHALL be sampled only in IDLE; a request still high the cycle after its ack SHALL be treated as a new transaction.
REQ-022 Minimum latency SHALL be: request to memReq 1 cycle; memAck to requester ack 1 cycle.
REQ-023 Requests changing while in BUSY or RESP SHALL NOT affect the transaction in flight.
REQ-024 memAck outside BUSY SHALL be ignored.
REQ-025 An 8-bit watchdog SHALL count cycles in BUSY, clear on BUSY entry, and saturate at 255.
REQ-026 When the watchdog reaches WDT_CYCLES with no memAck, SHALL set memErr (sticky) while staying in BUSY.

Reset
REQ-027 While rst is 1, SHALL force state IDLE and zero all outputs: acks, memReq, memWe, memAddr, memWData, iData, dData, memErr.
REQ-028 Reset mid-transaction SHALL abandon it silently: no ack, and a later stray memAck is ignored.
REQ-029 Round-robin pointer, if present, SHALL reset to point at the dcache requester.

Configuration
REQ-030 With macro MEM_ARB_RR_EN defined, SHALL use round-robin arbitration in order d -> w -> i, with highest priority moving to the requester after the last granted.
REQ-031 With MEM_ARB_RR_EN undefined, SHALL use fixed priority per REQ-015 and contain no pointer state.

Structure
REQ-032 ARCH_BITS and MEMORY_LINE_BITS SHALL come from the shared proc package.
REQ-033 The FSM state enum and requester-ID encoding (REQ_I, REQ_D, REQ_W) SHALL be added to the proc package.
REQ-034 SHALL contain one sub-module, mem_arb_pick: a combinational 3-way grant selector taking requests and pointer, returning a one-hot grant.

Verification
REQ-035 dReq only, dAddr=0x100; memory acks 10 cycles after memReq with 0xCAFE -> memReq rises next cycle, memWe=0, dAck one pulse, dData=0xCAFE.
REQ-036 dReq, iReq and wMemReq high in the same cycle (fixed priority) -> serviced d, w, i; wMemAck cycle shows memWe=1 and wAddrMem/wDataMem on the memory port.
REQ-037 Same as REQ-036 with MEM_ARB_RR_EN, all three held high -> grants rotate d, w, i, d; no requester starved.
REQ-038 wMemReq address changes during BUSY -> memAddr unchanged; new address served next transaction.
REQ-039 WDT_CYCLES=20, memAck withheld -> memErr=1 at cycle 20 of BUSY and stays 1; a late memAck completes normally.
REQ-040 rst in BUSY cycle 3 -> all outputs 0 next cycle, no ack; memAck two cycles later ignored.
